// File: rtl/led_pwm_pkg.sv
// Shared types for the LED PWM bank.
// Holds the channel mode encoding and the widths of the mode and
// channel-index fields of the configuration port.
package led_pwm_pkg;

    localparam int unsigned MODE_W   = 2;
    localparam int unsigned CH_IDX_W = 5;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared PWM time base: prescaler, PWM counter, blink phase and period wrap.
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   tick     - registered one-clock pulse, high while the prescaler is at DIV-1
//   pwm_cnt  - PWM counter, advances once per tick
//   phase    - blink phase, toggles on every period wrap
//   wrap_c   - combinational period-wrap strobe (tick with pwm_cnt all-ones)
module led_pwm_timebase #(
    parameter int unsigned DIV   = 65,
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             phase,
    output logic             wrap_c
);

    localparam int unsigned        PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_next;

    // Prescaler next value; tick is registered from it so tick tracks pre==DIV-1.
    assign pre_next = (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
    assign wrap_c   = tick && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre     <= '0;
            tick    <= 1'b0;
            pwm_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            pre  <= pre_next;
            tick <= (pre_next == PRE_MAX);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
            if (wrap_c) begin
                phase <= ~phase;
            end
        end
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of NUM_CH LED drivers with per-channel OFF / ON / BLINK / PWM modes.
// Optional feature: define LED_PWM_BANK_BREATHE_EN to add a shared triangle
// "breathe" ramp that PWM channels with duty 0 use as their duty.
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   cfg_we   - config write strobe
//   cfg_ch   - target channel index (writes to cfg_ch >= NUM_CH are ignored)
//   cfg_mode - channel mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_duty - channel duty value
//   led      - registered LED drives
//   tick     - one-clock pulse per PWM tick
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV    = 65,
    parameter int unsigned PWM_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic [NUM_CH-1:0]   led,
    output logic                tick
);

    logic [PWM_W-1:0]  pwm_cnt;
    logic              phase;
    logic              wrap_c;

    mode_e             mode_q [NUM_CH];
    logic [PWM_W-1:0]  duty_q [NUM_CH];
    logic [NUM_CH-1:0] led_next;
    logic [PWM_W-1:0]  duty_eff;

    led_pwm_timebase #(
        .DIV   (DIV),
        .PWM_W (PWM_W)
    ) u_timebase (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .pwm_cnt (pwm_cnt),
        .phase   (phase),
        .wrap_c  (wrap_c)
    );

`ifdef LED_PWM_BANK_BREATHE_EN
    logic [PWM_W-1:0] brth;
    logic             brth_up;

    // Triangle ramp stepped once per period; each endpoint is visited once.
    always_ff @(posedge clk) begin
        if (rst) begin
            brth    <= '0;
            brth_up <= 1'b1;
        end else if (wrap_c) begin
            if (brth_up) begin
                if (brth == '1) begin
                    brth_up <= 1'b0;
                    brth    <= brth - PWM_W'(1);
                end else begin
                    brth    <= brth + PWM_W'(1);
                end
            end else begin
                if (brth == '0) begin
                    brth_up <= 1'b1;
                    brth    <= brth + PWM_W'(1);
                end else begin
                    brth    <= brth - PWM_W'(1);
                end
            end
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = wrap_c;
`endif

    // Per-channel config registers; out-of-range indices match no channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_OFF;
                duty_q[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (32'(cfg_ch) == i) begin
                    mode_q[i] <= mode_e'(cfg_mode);
                    duty_q[i] <= cfg_duty;
                end
            end
        end
    end

    // LED decode from the current registers.
    always_comb begin
        led_next = '0;
        duty_eff = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            duty_eff = duty_q[i];
`ifdef LED_PWM_BANK_BREATHE_EN
            if (duty_q[i] == '0) begin
                duty_eff = brth;
            end
`endif
            unique case (mode_q[i])
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_BLINK: led_next[i] = phase;
                MODE_PWM:   led_next[i] = (pwm_cnt < duty_eff);
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Scoreboard bench for led_pwm_bank (NUM_CH=4, DIV=2, PWM_W=4).
// The stimulus process pushes the expected led/tick for each upcoming edge,
// computed from closed-form timing (counters measured from the last reset
// edge) and a shadow copy of the written configuration. A separate monitor
// pops and compares on every falling edge.
module tb_led_pwm_bank;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV    = 2;
    localparam int unsigned PWM_W  = 4;
    localparam int          PERIOD = DIV * 16;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [4:0]        cfg_ch;
    logic [1:0]        cfg_mode;
    logic [PWM_W-1:0]  cfg_duty;
    logic [NUM_CH-1:0] led;
    logic              tick;

    led_pwm_bank #(
        .NUM_CH (NUM_CH),
        .DIV    (DIV),
        .PWM_W  (PWM_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_duty (cfg_duty),
        .led      (led),
        .tick     (tick)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  led;
        logic        tick;
    } exp_t;

    exp_t sb[$];
    exp_t ex;

    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   rel    = 0;
    int   sh_mode [NUM_CH];
    int   sh_duty [NUM_CH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef LED_PWM_BANK_BREATHE_EN
    // Breathe value after k period wraps: 0,1..15,14..1,0,1..
    function automatic int tri_w(input int k);
        int m;
        m = k % 30;
        return (m <= 15) ? m : 30 - m;
    endfunction
`endif

    // Drive inputs for the next edge and queue what that edge must produce.
    task automatic cycle(input logic r, input logic we, input logic [4:0] ch,
                         input logic [1:0] md, input logic [3:0] dt);
        exp_t x;
        int   c;
        int   cnt;
        int   ph;
        int   d;
        rst      = r;
        cfg_we   = we;
        cfg_ch   = ch;
        cfg_mode = md;
        cfg_duty = dt;
        c        = cyc;
        x.cyc    = c + 1;
        x.led    = '0;
        x.tick   = 1'b0;
        if (!r) begin
            cnt    = ((c - rel) / DIV) % 16;
            ph     = ((c - rel) / PERIOD) % 2;
            x.tick = (((c + 1 - rel) % DIV) == DIV - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                d = sh_duty[i];
`ifdef LED_PWM_BANK_BREATHE_EN
                if (d == 0) d = tri_w((c - rel) / PERIOD);
`endif
                case (sh_mode[i])
                    1:       x.led[i] = 1'b1;
                    2:       x.led[i] = (ph != 0);
                    3:       x.led[i] = (cnt < d);
                    default: x.led[i] = 1'b0;
                endcase
            end
        end
        sb.push_back(x);
        if (r) begin
            rel = c + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_mode[i] = 0;
                sh_duty[i] = 0;
            end
        end else if (we && (int'(ch) < NUM_CH)) begin
            sh_mode[int'(ch)] = int'(md);
            sh_duty[int'(ch)] = int'(dt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 2'd0, 4'd0);
    endtask

    // Monitor: compare DUT outputs against the entry queued for this edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            ex = sb.pop_front();
            checks++;
            $display("FAIL stale_entry cyc=%0d: monitor reached cyc %0d, required compare at %0d",
                     ex.cyc, cyc, ex.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            ex = sb.pop_front();
            checks++;
            if (led !== ex.led || tick !== ex.tick) begin
                $display("FAIL led_tick cyc=%0d: got led=%b tick=%b, required led=%b tick=%b",
                         cyc, led, tick, ex.led, ex.tick);
            end else begin
                passes++;
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            sh_mode[i] = 0;
            sh_duty[i] = 0;
        end
        // Reset for three cycles; the last also carries a write that must lose.
        cycle(1'b1, 1'b0, 5'd0, 2'd0, 4'd0);
        cycle(1'b1, 1'b0, 5'd0, 2'd0, 4'd0);
        cycle(1'b1, 1'b1, 5'd0, 2'd1, 4'd0);
        idle(6);
        // ch1 PWM duty 4
        cycle(1'b0, 1'b1, 5'd1, 2'd3, 4'd4);
        idle(70);
        // ch2 BLINK, ch0 ON
        cycle(1'b0, 1'b1, 5'd2, 2'd2, 4'd0);
        cycle(1'b0, 1'b1, 5'd0, 2'd1, 4'd0);
        idle(70);
        // out-of-range channel is ignored
        cycle(1'b0, 1'b1, 5'd5, 2'd1, 4'd0);
        idle(6);
        // ch1 PWM duty all-ones
        cycle(1'b0, 1'b1, 5'd1, 2'd3, 4'd15);
        idle(41);
        // reset mid-period
        cycle(1'b1, 1'b0, 5'd0, 2'd0, 4'd0);
        idle(7);
        // ch3 PWM duty 0: breathe with the macro, constant 0 without
        cycle(1'b0, 1'b1, 5'd3, 2'd3, 4'd0);
        idle(32 * PERIOD);
        cfg_we = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end else begin
            passes++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
